// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, the IF/ID
// payload record, the bubble encoding and the word-alignment helper.
package fetch_pkg;

    // Fetch FSM: issue a request, wait for the response, or hold it while decode stalls.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // PC value that marks an IF/ID slot as a bubble.
    localparam logic [31:0] BUBBLE_PC = 32'hffffffff;

    // addi x0,x0,0
    localparam logic [31:0] NOP_ENCODING = 32'h00000013;

    // One IF/ID entry: instruction address and instruction word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } if_id_t;

    // Clears the byte-offset bits so every fetch address is a word address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hffff_fffc;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel between fetch (master) and
// instruction memory (slave). One request strobe, one response strobe.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, ins} buffer that parks a fetched instruction while decode
// is stalled. clear wins over load.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   clear,
    input  if_id_t load_data,
    output logic   valid,
    output if_id_t data
);

    logic   valid_d, valid_q;
    if_id_t data_d, data_q;

    // Next-state for the occupancy flag and payload.
    // NOTE: every signal assigned in an always_comb gets a default first; a path that leaves one unassigned infers a latch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    // Occupancy flag register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload register.
    // NOTE: the payload has no reset; it is only observed while valid_q is set, so resetting it would buy nothing.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one instruction
// memory request outstanding, drives the IF/ID register, freezes on a decode
// hazard and redirects on pipe_flush.
// Build option: FETCH_MISALIGN_CHECK_EN adds the sticky fetch_misaligned
// output and halts fetch after a flush to a non-word-aligned target.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INS  = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_flush,
    input  logic [31:0] jump_target,
    input  logic        data_hazard,
    fetch_if.master     imem,
    output logic [31:0] if_id__pc,
    output logic [31:0] if_id__ins
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam if_id_t BUBBLE = '{pc: BUBBLE_PC, ins: NOP_INS};

    fetch_state_e state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic         drop_d, drop_q;
    if_id_t       if_id_d, if_id_q;

    logic         hold_load, hold_clear, hold_valid;
    if_id_t       hold_data;
    if_id_t       fetched;
    logic         issue_req;
    logic         halted;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_d, misaligned_q;

    assign halted = misaligned_q;

    // Sticky flag: set by any flush to a target with a byte offset.
    always_comb begin
        misaligned_d = misaligned_q;
        if (pipe_flush && (jump_target[1:0] != 2'b00)) begin
            misaligned_d = 1'b1;
        end
    end

    // Misalignment flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign fetch_misaligned = misaligned_q;
`else
    assign halted = 1'b0;
`endif

    fetch_hold_buf u_hold_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (hold_load),
        .clear     (hold_clear),
        .load_data (fetched),
        .valid     (hold_valid),
        .data      (hold_data)
    );

    // A request goes out only from ISSUE with nowhere-blocked decode, never in
    // the redirect cycle itself, and never while reset is held.
    assign issue_req = rst_n && (state_q == ISSUE) && !hold_valid && !data_hazard
                       && !pipe_flush && !halted;

    assign fetched = '{pc: pc_q, ins: imem.imem_rdata};

    // Next-state, PC and IF/ID update; a flush overrides everything else.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        if_id_d    = if_id_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;

        if (pipe_flush) begin
            pc_d       = word_align(jump_target);
            if_id_d    = BUBBLE;
            hold_clear = 1'b1;
            if ((state_q == WAIT) && !imem.imem_valid) begin
                // Response still in flight: wait for it, then throw it away.
                state_d = WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = ISSUE;
                drop_d  = 1'b0;
            end
        end else begin
            // With decode free and nothing new to present, decode sees a bubble.
            if (!data_hazard) begin
                if_id_d = BUBBLE;
            end
            case (state_q)
                ISSUE: begin
                    if (issue_req) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_valid) begin
                        state_d = ISSUE;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else if (data_hazard) begin
                            hold_load = 1'b1;
                            state_d   = HOLD;
                        end else begin
                            if_id_d = fetched;
                            pc_d    = pc_q + 32'd4;
                        end
                    end
                end
                HOLD: begin
                    if (!data_hazard) begin
                        if_id_d    = hold_data;
                        pc_d       = pc_q + 32'd4;
                        hold_clear = 1'b1;
                        state_d    = ISSUE;
                    end
                end
                default: begin
                    state_d = ISSUE;
                end
            endcase
        end
    end

    // FSM, fetch PC, drop flag and IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            if_id_q <= BUBBLE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            if_id_q <= if_id_d;
        end
    end

    assign imem.imem_req  = issue_req;
    assign imem.imem_addr = pc_q;
    assign if_id__pc      = if_id_q.pc;
    assign if_id__ins     = if_id_q.ins;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: a directed vector table, a few
// hand-written multi-cycle sequences, then randomized traffic checked against
// a transaction-level reference model. A second instance with
// RESET_PC=32'hfffffffc exercises the PC wrap.
module tb_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] BUB = 32'hffffffff;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_flush = 1'b0;
    logic        data_hazard = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic [31:0] if_pc, if_ins, if2_pc, if2_ins;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misal, misal2;
`endif

    fetch_if mif ();
    fetch_if mif2 ();

    always #5 clk = ~clk;

    fetch #(.RESET_PC(32'h00000000), .NOP_INS(NOP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_flush  (pipe_flush),
        .jump_target (jump_target),
        .data_hazard (data_hazard),
        .imem        (mif),
        .if_id__pc   (if_pc),
        .if_id__ins  (if_ins)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned (misal)
`endif
    );

    fetch #(.RESET_PC(32'hfffffffc), .NOP_INS(NOP)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_flush  (1'b0),
        .jump_target (32'h0),
        .data_hazard (1'b0),
        .imem        (mif2),
        .if_id__pc   (if2_pc),
        .if_id__ins  (if2_ins)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned (misal2)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Memory responder for dut: one response, mem_lat idle cycles after the request cycle.
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    int          mem_lat  = 0;
    logic [31:0] mem_addr = 32'h0;
    // Zero-wait responder for dut2.
    bit          r2_pend = 1'b0;
    logic [31:0] r2_addr = 32'h0;

    // Reference model: architectural PC, outstanding/discard flags, stalled word, IF/ID.
    logic [31:0] m_pc, m_if_pc, m_if_ins, m_st_pc, m_st_ins;
    bit          m_busy, m_discard, m_st_v, m_halt;

    // Values sampled during the latest tick.
    logic        s_req, s2_req;
    logic [31:0] s_addr, s_pc, s_ins, s2_addr, s2_pc, s2_ins;

    typedef struct {
        logic        fl;
        logic [31:0] tg;
        logic        hz;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_if_pc = BUB; m_if_ins = NOP;
        m_st_pc = 32'h0; m_st_ins = 32'h0;
        m_busy = 1'b0; m_discard = 1'b0; m_st_v = 1'b0; m_halt = 1'b0;
    endtask

    // Called at posedge+1; asserts reset, checks reset values, releases at next posedge+1.
    task automatic apply_reset(input bit keep_mem);
        rst_n = 1'b0;
        pipe_flush = 1'b0; data_hazard = 1'b0;
        mif.imem_valid = 1'b0; mif2.imem_valid = 1'b0;
        #1;
        check("rst_req", mif.imem_req, 1'b0);
        check("rst_if_pc", if_pc, BUB);
        check("rst_if_ins", if_ins, NOP);
        model_reset();
        if (!keep_mem) mem_busy = 1'b0;
        r2_pend = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, sample and compare against the model, advance the model.
    task automatic tick(input logic fl, input logic [31:0] tg, input logic hz);
        logic        v, e_req, got, fresh;
        logic [31:0] rd;
        v = 1'b0;
        rd = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                v = 1'b1; rd = mem_addr ^ 32'h1; mem_busy = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        mif.imem_valid  = v;
        mif.imem_rdata  = rd;
        mif2.imem_valid = r2_pend;
        mif2.imem_rdata = r2_addr ^ 32'h1;
        pipe_flush = fl; jump_target = tg; data_hazard = hz;
        #1;
        s_req = mif.imem_req;   s_addr = mif.imem_addr;  s_pc = if_pc;   s_ins = if_ins;
        s2_req = mif2.imem_req; s2_addr = mif2.imem_addr; s2_pc = if2_pc; s2_ins = if2_ins;

        e_req = !m_busy && !m_st_v && !hz && !fl && !m_halt;
        check("imem_req", s_req, e_req);
        if (e_req) check("imem_addr", s_addr, m_pc);
        check("if_id_pc", s_pc, m_if_pc);
        check("if_id_ins", s_ins, m_if_ins);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("fetch_misaligned", misal, m_halt);
`endif
        if (s_req) begin
            check("one_outstanding", mem_busy, 1'b0);
            mem_busy = 1'b1; mem_addr = s_addr; mem_cnt = mem_lat;
        end
        r2_pend = s2_req; r2_addr = s2_addr;

        got = m_busy && v;
        if (fl) begin
            m_pc = tg & 32'hfffffffc;
            m_if_pc = BUB; m_if_ins = NOP; m_st_v = 1'b0;
            if (m_busy && !v) m_discard = 1'b1;
            else begin m_busy = 1'b0; m_discard = 1'b0; end
`ifdef FETCH_MISALIGN_CHECK_EN
            if (tg[1:0] != 2'b00) m_halt = 1'b1;
`endif
        end else begin
            fresh = got && !m_discard;
            if (got) begin m_busy = 1'b0; m_discard = 1'b0; end
            if (hz) begin
                if (fresh) begin m_st_v = 1'b1; m_st_pc = m_pc; m_st_ins = rd; end
            end else if (m_st_v) begin
                m_if_pc = m_st_pc; m_if_ins = m_st_ins; m_pc = m_pc + 32'd4; m_st_v = 1'b0;
            end else if (fresh) begin
                m_if_pc = m_pc; m_if_ins = rd; m_pc = m_pc + 32'd4;
            end else begin
                m_if_pc = BUB; m_if_ins = NOP;
            end
            if (e_req) m_busy = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit          seen;
        logic [31:0] tg;

        tbl[0]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h00, BUB,    NOP};
        tbl[1]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h00, BUB,    NOP};
        tbl[2]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h04, 32'h00, 32'h01};
        tbl[3]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h00, BUB,    NOP};
        tbl[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 32'h04, 32'h05};
        tbl[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h00, BUB,    NOP};
        tbl[6]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h00, 32'h08, 32'h09};
        tbl[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h40, BUB,    NOP};
        tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h00, BUB,    NOP};
        tbl[9]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h44, 32'h40, 32'h41};
        tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h00, BUB,    NOP};
        tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h00, BUB,    NOP};
        tbl[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h00, BUB,    NOP};
        tbl[13] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h48, 32'h44, 32'h45};

        mif.imem_valid = 1'b0;  mif.imem_rdata = 32'h0;
        mif2.imem_valid = 1'b0; mif2.imem_rdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        apply_reset(1'b0);

        // Zero-wait memory, flush+hazard collision, hazard on a zero-wait response.
        mem_lat = 0;
        for (int i = 0; i < 14; i++) begin
            tick(tbl[i].fl, tbl[i].tg, tbl[i].hz);
            check($sformatf("tbl%0d_req", i), s_req, tbl[i].e_req);
            if (tbl[i].e_req) check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
            check($sformatf("tbl%0d_ins", i), s_ins, tbl[i].e_ins);
            if (i == 0) begin
                check("wrap_req0", s2_req, 1'b1);
                check("wrap_addr0", s2_addr, 32'hfffffffc);
            end
            if (i == 2) begin
                check("wrap_req1", s2_req, 1'b1);
                check("wrap_addr1", s2_addr, 32'h00000000);
                check("wrap_pc", s2_pc, 32'hfffffffc);
                check("wrap_ins", s2_ins, 32'hfffffffd);
            end
        end

        // Hazard held over a slow response: IF/ID frozen, released from the hold buffer.
        tick(1'b0, 32'h0, 1'b0);
        mem_lat = 2;
        tick(1'b0, 32'h0, 1'b0);
        check("hz_req", s_req, 1'b1);
        check("hz_addr", s_addr, 32'h4c);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 32'h0, 1'b1);
            check("hz_frozen_pc", s_pc, BUB);
            check("hz_frozen_req", s_req, 1'b0);
        end
        tick(1'b0, 32'h0, 1'b0);
        check("hz_release_pc", s_pc, BUB);
        tick(1'b0, 32'h0, 1'b0);
        check("hz_held_pc", s_pc, 32'h4c);
        check("hz_held_ins", s_ins, 32'h4d);
        check("hz_next_req", s_req, 1'b1);
        check("hz_next_addr", s_addr, 32'h50);

        // Flush while the 0x50 request is in flight: its response is discarded.
        tick(1'b1, 32'h100, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        check("fl_wait_req", s_req, 1'b0);
        check("fl_wait_pc", s_pc, BUB);
        tick(1'b0, 32'h0, 1'b0);
        check("fl_drop_req", s_req, 1'b0);
        check("fl_drop_pc", s_pc, BUB);
        tick(1'b0, 32'h0, 1'b0);
        check("fl_new_req", s_req, 1'b1);
        check("fl_new_addr", s_addr, 32'h100);
        check("fl_new_pc", s_pc, BUB);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick(1'b0, 32'h0, 1'b0);
            if (s_pc != BUB) seen = 1'b1;
        end
        check("fl_target_pc", s_pc, 32'h100);
        check("fl_target_ins", s_ins, 32'h101);

        // Reset mid-request; the stale response lands in ISSUE after reset and is ignored.
        tick(1'b0, 32'h0, 1'b0);
        mem_cnt = 0;
        mem_lat = 0;
        apply_reset(1'b1);
        tick(1'b0, 32'h0, 1'b0);
        check("rst_first_req", s_req, 1'b1);
        check("rst_first_addr", s_addr, 32'h0);
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        check("rst_first_pc", s_pc, 32'h0);
        check("rst_first_ins", s_ins, 32'h1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            mem_lat = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: tg = 32'hfffffff8;
                1: tg = 32'hfffffffc | 32'($urandom_range(0, 3));
                default: tg = $urandom;
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            tg = tg & 32'hfffffffc;
`endif
            tick($urandom_range(0, 15) == 0, tg, $urandom_range(0, 3) == 0);
        end

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect: sticky flag, no further requests, bubbles only.
        tick(1'b1, 32'h102, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 32'h0, k[0]);
            check("mis_flag", misal, 1'b1);
            check("mis_req", s_req, 1'b0);
            check("mis_pc", s_pc, BUB);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
